// File: rtl/seq_det_ctrl.sv
// One-shot, abortable sequence detector: scans SEQ_W-PAT_W+1 overlapping windows MSB-first, one per clock.
// Optional per-window match mask is built when SEQ_DET_POS_MASK_EN is defined; otherwise match_pos is tied to 0.
//
// state | meaning
// IDLE  | waiting for start; count/match_pos hold the last completed result
// SCAN  | comparing window idx of seq_r against pat_r, accumulating matches
// DONE  | done pulse; count/match_pos were loaded on entry
module seq_det_ctrl #(
  parameter int SEQ_W = 8,
  parameter int PAT_W = 3,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [SEQ_W-1:0]       seq,
  input  logic [PAT_W-1:0]       pattern,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       count,
  output logic [SEQ_W-PAT_W:0]   match_pos
);

  localparam int WIN   = SEQ_W - PAT_W + 1;
  localparam int IDX_W = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state;
  logic [SEQ_W-1:0]  seq_r;
  logic [PAT_W-1:0]  pat_r;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  acc;
  logic [CNT_W-1:0]  acc_nxt;
  logic [SEQ_W-1:0]  seq_sh;
  logic [PAT_W-1:0]  win;
  logic              hit;

  // Shifting left by idx brings window idx to the top of the word.
  always_comb begin
    seq_sh  = seq_r << idx;
    win     = seq_sh[SEQ_W-1 -: PAT_W];
    hit     = (win == pat_r);
    acc_nxt = acc + CNT_W'(hit);
  end

`ifdef SEQ_DET_POS_MASK_EN
  logic [WIN-1:0] pos_r;
  logic [WIN-1:0] pos_nxt;

  always_comb begin
    pos_nxt = pos_r;
    if (hit) pos_nxt[idx] = 1'b1;
  end
`else
  assign match_pos = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      seq_r <= '0;
      pat_r <= '0;
      idx   <= '0;
      acc   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      count <= '0;
`ifdef SEQ_DET_POS_MASK_EN
      pos_r     <= '0;
      match_pos <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            seq_r <= seq;
            pat_r <= pattern;
            idx   <= '0;
            acc   <= '0;
`ifdef SEQ_DET_POS_MASK_EN
            pos_r <= '0;
`endif
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc <= acc_nxt;
`ifdef SEQ_DET_POS_MASK_EN
            pos_r <= pos_nxt;
`endif
            if (idx == LAST_IDX) begin
              count <= acc_nxt;
`ifdef SEQ_DET_POS_MASK_EN
              match_pos <= pos_nxt;
`endif
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Sequential controller for the 8-bit sequence detector on the Runber board. On a `start` pulse it snapshots the DIP-switch sequence and the 3-bit key pattern, then scans the overlapping windows one per clock from MSB to LSB, accumulating a match count. It reports the count with a single-cycle `done` pulse. It replaces free-running parallel comparison with a one-shot, abortable scan that the display logic can consume directly.

## Interface
Parameters:
- `SEQ_W`, default 8: sequence width.
- `PAT_W`, default 3: pattern width. Requires 1 ≤ PAT_W ≤ SEQ_W.
- `CNT_W`, default 4: count width. Requires SEQ_W-PAT_W+1 ≤ 2^CNT_W-1.

Ports (clock and reset first):
- `clk`  in  1  system clock. The block has one clock domain; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request a scan. Sampled only in IDLE.
- `abort`  in  1  cancel an in-progress scan. Has priority over `start`.
- `seq`  in  SEQ_W  sequence under test.
- `pattern`  in  PAT_W  pattern to search for.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse when `count` is updated.
- `count`  out  CNT_W  number of matching windows in the last completed scan.
- `match_pos`  out  SEQ_W-PAT_W+1  per-window match mask (see Configuration).

## Operation
- WIN = SEQ_W-PAT_W+1 (6 at defaults). Window i compares `seq[SEQ_W-1-i -: PAT_W]` against the pattern. Window 0 is the MSB window, `seq[7:5]`.
- States:
  - IDLE, SCAN, DONE.
  - Internal registers: `seq_r`, `pat_r`, `idx` (index width large enough for WIN-1), `acc` (CNT_W bits), `pos_r`.
- IDLE:
  - `start`=1 and `abort`=0: capture `seq`→`seq_r` and `pattern`→`pat_r`; clear `idx`, `acc` and `pos_r`; go to SCAN.
  - Otherwise stay in IDLE.
- SCAN, on each cycle:
  - Compare window `idx` of `seq_r` against `pat_r`.
  - On a match: `acc`+1 and set `pos_r[idx]`.
  - If `idx`=WIN-1, go to DONE. Otherwise `idx`+1.
- DONE:
  - Assert `done`=1.
  - `count` and `match_pos` were loaded from the final `acc`/`pos_r` values at the edge that entered DONE. The final-window result is included.
  - Return to IDLE on the next edge.
- Live `seq` and `pattern` changes after capture have no effect on the scan in progress.
- `start` while `busy`=1 (SCAN or DONE) is ignored. Requests are not queued.
- `abort` in SCAN: go to IDLE at the next edge. `count` and `match_pos` keep their previous values and no `done` pulse is produced.
- `abort` in DONE: no effect, because `done` is already asserted that cycle.
- `abort` together with `start` in IDLE: stay in IDLE.
- Overlapping matches are all counted. For example, pattern 111 on 8'hFF gives 6.
- `acc` cannot overflow, given the CNT_W constraint. Compare `acc`+1 in CNT_W bits with no saturation.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `count`=0, `match_pos`=0, and all internal registers 0.
- Reset asserted mid-scan: outputs return to reset values immediately. No `done` pulse is produced.
- `start` sampled high at edge k:
  - `busy`=1 from k+1.
  - SCAN occupies cycles k+1 … k+WIN.
  - `done`=1 and new `count` valid in cycle k+WIN+1 (k+7 at defaults).
  - `busy`=0 from k+WIN+2.
- Minimum spacing between start pulses that are accepted: WIN+2 cycles.
- `count` and `match_pos` change only at the edge that enters DONE, and otherwise hold.

## Configuration
- Macro: `SEQ_DET_POS_MASK_EN`.
- Defined: `pos_r` is implemented and `match_pos` reports the per-window mask of the last completed scan.
- Undefined: `pos_r` logic is removed and `match_pos` is tied to 0. `count`, `done` and `busy` behave identically in both builds.

## Test plan
- `seq`=8'b1011_0101, `pattern`=3'b101, start pulse → `done` at k+7, `count`=3, `match_pos`=6'b101001 (mask only when the macro is defined).
- `seq`=8'hFF, `pattern`=3'b111 → `count`=6, `match_pos`=6'b111111. Then `seq`=8'h00, same pattern → `count`=0, `match_pos`=0.
- Start a scan, then change `seq` and `pattern` every cycle during SCAN → result matches the values captured at start.
- Assert `abort` at k+3 → no `done` pulse, `busy` low at k+4, `count` keeps the prior value (e.g. 3). A subsequent start runs normally.
- Pulse `start` at k+2 and k+7 → both ignored. Exactly one `done`. A start at k+8 is accepted.
- Assert `rst` at k+4 → `busy`, `done`, `count` and `match_pos` are 0 asynchronously. After release, a start produces a correct result.
